seq_nonrestoring_divider: RTL and testbench

Parametrised, multi-cycle unsigned integer divider using the non-restoring algorithm. It computes one quotient bit per clock through a shared add/subtract datapath. Operands are accepted and results delivered on valid/ready handshakes, so the block can sit between pipeline stages of the arithmetic unit. It replaces the fixed 4-bit combinational divider with a width-generic, registered, back-pressurable unit that flags divide-by-zero.

---
 rtl/seq_nonrestoring_divider.sv | 106 ++++++++++
 tb/tb_seq_nonrestoring_divider.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_nonrestoring_divider.sv
// rtl/seq_nonrestoring_divider.sv - multi-cycle unsigned non-restoring divider with valid/ready handshakes
module seq_nonrestoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          state;
  logic [WIDTH:0]  a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]   cnt;

  logic [WIDTH:0]  d_ext;
  logic [WIDTH:0]  a_sh;
  logic [WIDTH:0]  a_step;

  // One non-restoring step: shift {A,Q} left, then add or subtract D by the old sign of A
  always_comb begin
    d_ext  = {1'b0, d};
    a_sh   = {a[WIDTH-1:0], q[WIDTH-1]};
    a_step = a[WIDTH] ? (a_sh + d_ext) : (a_sh - d_ext);
  end

  // Result buses come straight from the working registers; the zero-divisor path preloads them
  assign quotient  = q;
  assign remainder = a[WIDTH-1:0];

  // Control FSM and datapath registers with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
      a           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d        <= divisor;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              a           <= {1'b0, dividend};
              q           <= '1;
              cnt         <= '0;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              a           <= '0;
              q           <= dividend;
              cnt         <= CW'(WIDTH);
              div_by_zero <= 1'b0;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          a   <= a_step;
          q   <= {q[WIDTH-2:0], ~a_step[WIDTH]};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // A negative final partial remainder is restored by adding D back once
          if (a[WIDTH]) begin
            a <= a + d_ext;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// tb/tb_seq_nonrestoring_divider.sv - self-checking bench for seq_nonrestoring_divider at WIDTH 4, 8 and 16
module tb_seq_nonrestoring_divider;

  logic clk;
  logic rst_n;

  logic        iv4, ir4, ov4, or4, z4;
  logic [3:0]  x4, y4, q4, r4;
  logic        iv8, ir8, ov8, or8, z8;
  logic [7:0]  x8, y8, q8, r8;
  logic        iv16, ir16, ov16, or16, z16;
  logic [15:0] x16, y16, q16, r16;

  int tests;
  int fails;

  seq_nonrestoring_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .dividend(x4), .divisor(y4),
    .out_valid(ov4), .out_ready(or4), .quotient(q4), .remainder(r4), .div_by_zero(z4)
  );

  seq_nonrestoring_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .dividend(x8), .divisor(y8),
    .out_valid(ov8), .out_ready(or8), .quotient(q8), .remainder(r8), .div_by_zero(z8)
  );

  seq_nonrestoring_divider #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .dividend(x16), .divisor(y16),
    .out_valid(ov16), .out_ready(or16), .quotient(q16), .remainder(r16), .div_by_zero(z16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_ov(input int w);
    case (w)
      4:       return ov4;
      8:       return ov8;
      default: return ov16;
    endcase
  endfunction

  function automatic logic get_ir(input int w);
    case (w)
      4:       return ir4;
      8:       return ir8;
      default: return ir16;
    endcase
  endfunction

  function automatic logic get_z(input int w);
    case (w)
      4:       return z4;
      8:       return z8;
      default: return z16;
    endcase
  endfunction

  function automatic logic [31:0] get_q(input int w);
    case (w)
      4:       return {28'd0, q4};
      8:       return {24'd0, q8};
      default: return {16'd0, q16};
    endcase
  endfunction

  function automatic logic [31:0] get_r(input int w);
    case (w)
      4:       return {28'd0, r4};
      8:       return {24'd0, r8};
      default: return {16'd0, r16};
    endcase
  endfunction

  task automatic set_in(input int w, input logic v, input logic [31:0] x, input logic [31:0] y);
    case (w)
      4:       begin iv4 = v;  x4 = x[3:0];   y4 = y[3:0];   end
      8:       begin iv8 = v;  x8 = x[7:0];   y8 = y[7:0];   end
      default: begin iv16 = v; x16 = x[15:0]; y16 = y[15:0]; end
    endcase
  endtask

  // Present operands for one accepting edge, then count edges until out_valid appears
  task automatic do_div(input int w, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] q, output logic [31:0] r, output logic z, output int lat);
    check("ready_before_accept", {31'd0, get_ir(w)}, 32'd1);
    set_in(w, 1'b1, x, y);
    @(posedge clk); #1;
    set_in(w, 1'b0, 32'd0, 32'd0);
    lat = 0;
    while (!get_ov(w) && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    q = get_q(w);
    r = get_r(w);
    z = get_z(w);
  endtask

  // Reference: plain integer division; zero divisor yields all ones, the dividend and a flag
  task automatic check_div(input int w, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] q, r, eq, er, mask;
    logic z, ez;
    int lat, elat;
    mask = (32'd1 << w) - 32'd1;
    if (y == 32'd0) begin
      eq = mask; er = x; ez = 1'b1; elat = 0;
    end else begin
      eq = x / y; er = x % y; ez = 1'b0; elat = w + 1;
    end
    do_div(w, x, y, q, r, z, lat);
    check("latency", lat, elat);
    check("quotient", q, eq);
    check("remainder", r, er);
    check("div_by_zero", {31'd0, z}, {31'd0, ez});
    @(posedge clk); #1;
    check("idle_after_handshake", {31'd0, get_ir(w)}, 32'd1);
  endtask

  initial begin
    logic [31:0] q, r;
    logic z;
    int lat;
    logic [31:0] x, y;

    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    or4 = 1'b1; or8 = 1'b1; or16 = 1'b1;
    set_in(4, 1'b0, 32'd0, 32'd0);
    set_in(8, 1'b0, 32'd0, 32'd0);
    set_in(16, 1'b0, 32'd0, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, ir8}, 32'd1);
    check("rst_out_valid", {31'd0, ov8}, 32'd0);
    check("rst_quotient", {24'd0, q8}, 32'd0);
    check("rst_remainder", {24'd0, r8}, 32'd0);
    check("rst_div_by_zero", {31'd0, z8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    check_div(4, 32'd13, 32'd4);
    check_div(8, 32'd255, 32'd16);
    check_div(8, 32'd7, 32'd200);
    check_div(8, 32'hA5, 32'd0);
    check_div(8, 32'd10, 32'd3);

    // Backpressure: result must hold and new operands must be ignored while DONE stalls
    or8 = 1'b0;
    do_div(8, 32'd100, 32'd7, q, r, z, lat);
    check("bp_latency", lat, 32'd9);
    check("bp_quotient", q, 32'd14);
    check("bp_remainder", r, 32'd2);
    set_in(8, 1'b1, 32'd50, 32'd5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid_hold", {31'd0, ov8}, 32'd1);
      check("bp_in_ready_low", {31'd0, ir8}, 32'd0);
      check("bp_quotient_hold", {24'd0, q8}, 32'd14);
      check("bp_remainder_hold", {24'd0, r8}, 32'd2);
    end
    set_in(8, 1'b0, 32'd0, 32'd0);
    or8 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", {31'd0, ov8}, 32'd0);
    check("bp_release_in_ready", {31'd0, ir8}, 32'd1);
    @(posedge clk); #1;
    check("bp_no_stray_accept", {31'd0, ir8}, 32'd1);

    // Reset in the middle of a run aborts at once, without waiting for a clock edge
    set_in(8, 1'b1, 32'd200, 32'd3);
    @(posedge clk); #1;
    set_in(8, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, ir8}, 32'd1);
    check("abort_out_valid", {31'd0, ov8}, 32'd0);
    check("abort_quotient", {24'd0, q8}, 32'd0);
    check("abort_remainder", {24'd0, r8}, 32'd0);
    check("abort_div_by_zero", {31'd0, z8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_div(8, 32'd9, 32'd9);

    // Exhaustive sweep at WIDTH=4
    for (int xi = 0; xi < 16; xi++) begin
      for (int yi = 0; yi < 16; yi++) begin
        check_div(4, 32'(xi), 32'(yi));
      end
    end

    // Random sweep at WIDTH=16 mixing small, full-range and zero divisors
    for (int n = 0; n < 2000; n++) begin
      x = $urandom & 32'hFFFF;
      case ($urandom_range(0, 9))
        0:       y = 32'd0;
        1, 2, 3: y = $urandom_range(1, 15);
        4:       y = x;
        default: y = $urandom & 32'hFFFF;
      endcase
      check_div(16, x, y);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
